// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access over req/ack, branch resolve, MEM/WB register.
// Optional MEM_TIMEOUT_EN adds an ACCESS watchdog with a sticky mem_err output.
module mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_in,
  input  logic              jump_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] adder_in,
  input  logic [1:0]        aluzero_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] readdata2_in,
  input  logic [REG_W-1:0]  mux_in,
  mem_stage_if.master       dmem,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              valid_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] readdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  mux_out
`ifdef MEM_TIMEOUT_EN
  , output logic            mem_err
`endif
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic              regw_q, regw_d;
  logic              m2r_q, m2r_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  mux_q, mux_d;
  logic              mem_op_c;
  logic              unused_aluzero_hi;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout_c;

  // Fires in the ACCESS cycle that brings the ACCESS-cycle count to TIMEOUT_CYCLES.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err   = err_q;
`endif

  assign mem_op_c          = MemRead_in | MemWrite_in;
  assign pc_src            = jump_in | (branch_in & aluzero_in[0]);
  assign pc_target         = adder_in;
  assign unused_aluzero_hi = aluzero_in[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      regw_q  <= 1'b0;
      m2r_q   <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      mux_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      regw_q  <= regw_d;
      m2r_q   <= m2r_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      mux_q   <= mux_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and MEM/WB payload; the MEM/WB default is a bubble.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    regw_d  = 1'b0;
    m2r_d   = 1'b0;
    rdata_d = '0;
    alu_d   = '0;
    mux_d   = '0;
    stall   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op_c) begin
          stall   = 1'b1;
          state_d = ACCESS;
          req_d   = 1'b1;
          addr_d  = alu_in;
          wdata_d = readdata2_in;
          we_d    = MemWrite_in & ~MemRead_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          valid_d = 1'b1;
          regw_d  = RegWrite_in;
          m2r_d   = MemtoReg_in;
          alu_d   = alu_in;
          mux_d   = mux_in;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          regw_d  = RegWrite_in;
          m2r_d   = MemtoReg_in;
          rdata_d = we_q ? '0 : dmem.dmem_rdata;
          alu_d   = alu_in;
          mux_d   = mux_in;
`ifdef MEM_TIMEOUT_EN
        end else if (timeout_c) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          m2r_d   = MemtoReg_in;
          alu_d   = alu_in;
          mux_d   = mux_in;
          err_d   = 1'b1;
`endif
        end else begin
          stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign valid_out    = valid_q;
  assign RegWrite_out = regw_q;
  assign MemtoReg_out = m2r_q;
  assign readdata_out = rdata_q;
  assign alu_out      = alu_q;
  assign mux_out      = mux_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle sequences, random mix.
module tb_mem_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TO     = 4;

  logic clk = 1'b0;
  logic rst;
  logic branch_in, jump_in, MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
  logic [DATA_W-1:0] adder_in, alu_in, readdata2_in;
  logic [1:0]        aluzero_in;
  logic [REG_W-1:0]  mux_in;
  logic stall, pc_src, valid_out, RegWrite_out, MemtoReg_out;
  logic [DATA_W-1:0] pc_target, readdata_out, alu_out;
  logic [REG_W-1:0]  mux_out;
`ifdef MEM_TIMEOUT_EN
  logic mem_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.DATA_W(DATA_W)) dmem ();

  mem_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .branch_in(branch_in), .jump_in(jump_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .adder_in(adder_in), .aluzero_in(aluzero_in), .alu_in(alu_in),
    .readdata2_in(readdata2_in), .mux_in(mux_in),
    .dmem(dmem),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .valid_out(valid_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .readdata_out(readdata_out), .alu_out(alu_out), .mux_out(mux_out)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  typedef struct {
    logic              br;
    logic              jp;
    logic [1:0]        az;
    logic [DATA_W-1:0] adder;
    logic [DATA_W-1:0] alu;
    logic              rw;
    logic              m2r;
    logic [REG_W-1:0]  mux;
    logic              exp_pc;
    logic [DATA_W-1:0] exp_alu;
    logic [REG_W-1:0]  exp_mux;
    logic              exp_rw;
    logic              exp_m2r;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_nop();
    branch_in = 0; jump_in = 0; MemRead_in = 0; MemWrite_in = 0;
    RegWrite_in = 0; MemtoReg_in = 0; adder_in = '0; aluzero_in = '0;
    alu_in = '0; readdata2_in = '0; mux_in = '0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = '0;
  endtask

  // One non-memory instruction; a spurious ack may be driven to prove IDLE ignores it.
  task automatic do_alu(input logic br, input logic jp, input logic [1:0] az,
                        input logic [DATA_W-1:0] adder, input logic [DATA_W-1:0] alu,
                        input logic rw, input logic m2r, input logic [REG_W-1:0] mux,
                        input logic ack, input logic [DATA_W-1:0] rd,
                        input logic exp_pc, input logic [DATA_W-1:0] exp_alu,
                        input logic [REG_W-1:0] exp_mux, input logic exp_rw, input logic exp_m2r);
    set_nop();
    branch_in = br; jump_in = jp; aluzero_in = az; adder_in = adder; alu_in = alu;
    RegWrite_in = rw; MemtoReg_in = m2r; mux_in = mux;
    readdata2_in = $urandom;
    dmem.dmem_ack = ack; dmem.dmem_rdata = rd;
    #3;
    check("alu_stall", stall, 0);
    check("pc_src", pc_src, exp_pc);
    check("pc_target", pc_target, adder);
    @(posedge clk); #1;
    check("alu_valid", valid_out, 1);
    check("alu_out", alu_out, exp_alu);
    check("alu_mux_out", mux_out, exp_mux);
    check("alu_regwrite", RegWrite_out, exp_rw);
    check("alu_memtoreg", MemtoReg_out, exp_m2r);
    check("alu_readdata", readdata_out, 0);
    check("alu_req", dmem.dmem_req, 0);
    dmem.dmem_ack = 0;
  endtask

  // Memory op acked in ACCESS cycle lat (lat>=1); cycle 0 is the IDLE entry cycle.
  task automatic do_mem(input logic rd, input logic wr, input logic [DATA_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic rw, input logic m2r,
                        input logic [REG_W-1:0] mux, input int lat,
                        input logic [DATA_W-1:0] rdata, output int stall_cnt);
    logic exp_we;
    exp_we = wr & ~rd;
    stall_cnt = 0;
    set_nop();
    MemRead_in = rd; MemWrite_in = wr; alu_in = addr; readdata2_in = wdata;
    RegWrite_in = rw; MemtoReg_in = m2r; mux_in = mux; adder_in = $urandom;
    for (int k = 0; k <= lat; k++) begin
      dmem.dmem_ack   = (k == lat);
      dmem.dmem_rdata = (k == lat) ? rdata : DATA_W'($urandom);
      #3;
      if (stall) stall_cnt++;
      check("mem_stall", stall, (k < lat));
      check("mem_pc_src", pc_src, 0);
      @(posedge clk); #1;
      if (k < lat) begin
        check("mem_req_hi", dmem.dmem_req, 1);
        check("mem_addr", dmem.dmem_addr, addr);
        check("mem_wdata", dmem.dmem_wdata, wdata);
        check("mem_we", dmem.dmem_we, exp_we);
        check("mem_bubble_valid", valid_out, 0);
        check("mem_bubble_rw", RegWrite_out, 0);
      end else begin
        check("mem_req_lo", dmem.dmem_req, 0);
        check("mem_valid", valid_out, 1);
        check("mem_regwrite", RegWrite_out, rw);
        check("mem_memtoreg", MemtoReg_out, m2r);
        check("mem_readdata", readdata_out, exp_we ? '0 : rdata);
        check("mem_alu_out", alu_out, addr);
        check("mem_mux_out", mux_out, mux);
      end
    end
    dmem.dmem_ack = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    tbl[0] = '{0, 0, 2'b00, 32'h0,    32'h0000_002A, 1, 0, 5'd5,  0, 32'h0000_002A, 5'd5,  1, 0};
    tbl[1] = '{1, 0, 2'b01, 32'h80,   32'h0000_0011, 0, 0, 5'd0,  1, 32'h0000_0011, 5'd0,  0, 0};
    tbl[2] = '{1, 0, 2'b10, 32'h80,   32'h0000_0022, 0, 0, 5'd1,  0, 32'h0000_0022, 5'd1,  0, 0};
    tbl[3] = '{0, 1, 2'b00, 32'h200,  32'h0000_0033, 1, 0, 5'd2,  1, 32'h0000_0033, 5'd2,  1, 0};
    tbl[4] = '{1, 0, 2'b11, 32'h1234, 32'h8000_0000, 1, 1, 5'd30, 1, 32'h8000_0000, 5'd30, 1, 1};
    tbl[5] = '{0, 0, 2'b01, 32'h0,    32'hFFFF_FFFF, 0, 1, 5'd31, 0, 32'hFFFF_FFFF, 5'd31, 0, 1};

    set_nop();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_req", dmem.dmem_req, 0);
    check("rst_we", dmem.dmem_we, 0);
    check("rst_addr", dmem.dmem_addr, 0);
    check("rst_wdata", dmem.dmem_wdata, 0);
    check("rst_valid", valid_out, 0);
    check("rst_regwrite", RegWrite_out, 0);
    check("rst_memtoreg", MemtoReg_out, 0);
    check("rst_readdata", readdata_out, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_mux_out", mux_out, 0);
    check("rst_stall", stall, 0);
`ifdef MEM_TIMEOUT_EN
    check("rst_mem_err", mem_err, 0);
`endif
    rst = 0;

    for (int i = 0; i < 6; i++)
      do_alu(tbl[i].br, tbl[i].jp, tbl[i].az, tbl[i].adder, tbl[i].alu,
             tbl[i].rw, tbl[i].m2r, tbl[i].mux, (i % 2 == 1), 32'hBAD0_BAD0,
             tbl[i].exp_pc, tbl[i].exp_alu, tbl[i].exp_mux, tbl[i].exp_rw, tbl[i].exp_m2r);

    // Load acked three cycles after req rises: four stall cycles.
    do_mem(1, 0, 32'h100, 32'h0, 1, 1, 5'd7, 4, 32'hDEAD_BEEF, sc);
    check("load_stall_cycles", sc, 4);
    // Store acked in the second ACCESS cycle: two stall cycles, RegWrite follows input.
    do_mem(0, 1, 32'h40, 32'h1234, 0, 0, 5'd0, 2, 32'hFFFF_0000, sc);
    check("store_stall_cycles", sc, 2);
    // Fastest load, and read-wins when both strobes are set.
    do_mem(1, 0, 32'h44, 32'h0, 1, 1, 5'd9, 1, 32'hCAFE_F00D, sc);
    check("fast_stall_cycles", sc, 1);
    do_mem(1, 1, 32'h48, 32'h5555, 1, 1, 5'd3, 1, 32'h0BAD_CAFE, sc);

`ifdef MEM_TIMEOUT_EN
    set_nop();
    MemRead_in = 1; RegWrite_in = 1; alu_in = 32'h300; mux_in = 5'd4;
    for (int k = 0; k <= int'(TO); k++) begin
      #3;
      check("to_stall", stall, (k < int'(TO)));
      @(posedge clk); #1;
      if (k < int'(TO)) check("to_req_hi", dmem.dmem_req, 1);
    end
    check("to_req_lo", dmem.dmem_req, 0);
    check("to_mem_err", mem_err, 1);
    check("to_valid", valid_out, 1);
    check("to_killed_rw", RegWrite_out, 0);
    do_alu(0, 0, 2'b00, 32'h0, 32'h77, 1, 0, 5'd1, 0, 32'h0, 0, 32'h77, 5'd1, 1, 0);
    check("to_err_sticky", mem_err, 1);
    // Ack in the timeout cycle completes the access normally.
    do_mem(1, 0, 32'h304, 32'h0, 1, 0, 5'd6, int'(TO), 32'h1357_9BDF, sc);
`endif

    // Reset in the second ACCESS cycle; a late ack afterwards is ignored.
    set_nop();
    MemRead_in = 1; RegWrite_in = 1; alu_in = 32'h500; mux_in = 5'd8;
    #3;
    check("ra_entry_stall", stall, 1);
    @(posedge clk); #1;
    check("ra_req_hi", dmem.dmem_req, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("ra_req", dmem.dmem_req, 0);
    check("ra_addr", dmem.dmem_addr, 0);
    check("ra_valid", valid_out, 0);
    check("ra_regwrite", RegWrite_out, 0);
    check("ra_alu_out", alu_out, 0);
    check("ra_mux_out", mux_out, 0);
`ifdef MEM_TIMEOUT_EN
    check("ra_mem_err", mem_err, 0);
`endif
    set_nop();
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'h5A5A_5A5A;
    #3;
    check("ra_stall", stall, 0);
    @(posedge clk); #1;
    check("ra_late_ack_rdata", readdata_out, 0);
    check("ra_late_ack_req", dmem.dmem_req, 0);
    check("ra_late_ack_valid", valid_out, 1);
    dmem.dmem_ack = 0;

    // Random instruction mix against the arithmetic timing model.
    for (int n = 0; n < 80; n++) begin
      logic br, jp, rw, m2r, rd, wr;
      logic [1:0] az;
      logic [DATA_W-1:0] a, b, r;
      logic [REG_W-1:0] m;
      br = 1'($urandom); jp = 1'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
      az = 2'($urandom); a = $urandom; b = $urandom; r = $urandom; m = REG_W'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_alu(br, jp, az, b, a, rw, m2r, m, 1'($urandom), r,
               jp | (br & az[0]), a, m, rw, m2r);
      end else begin
        rd = 1'($urandom); wr = ~rd | 1'($urandom);
        do_mem(rd, wr, a, b, rw, m2r, m, int'($urandom_range(1, TO)), r, sc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
